// File: rtl/bishift_pkg.sv
// Shared constants, requester IDs and FSM state type for the bidirectional
// shifter arbiter and its datapath.
package bishift_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bishift_parallel_8.sv
// Combinational 8-bit logical shifter, left or right with zero fill.
// A left shift is a right shift applied to the bit-reversed operand.
module bishift_parallel_8 (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  input  logic       right,
  output logic [7:0] out
);
  import bishift_pkg::*;

  logic [7:0] pre;
  logic [7:0] s0;
  logic [7:0] s1;
  logic [7:0] s2;

  always_comb begin
    pre = right ? data : bit_rev(data);
    s0  = sel[0] ? {1'b0,    pre[7:1]} : pre;
    s1  = sel[1] ? {2'b00,   s0[7:2]}  : s0;
    s2  = sel[2] ? {4'b0000, s1[7:4]}  : s1;
    out = right ? s2 : bit_rev(s2);
  end

endmodule

// File: rtl/bishift_arb_ctrl_8.sv
// Round-robin arbiter sharing one bishift_parallel_8 between two requesters;
// one-deep result register with valid/ready handshake and per-requester grant counters.
module bishift_arb_ctrl_8 #(
  parameter int DATA_W  = bishift_pkg::DATA_W,
  parameter int SHAMT_W = bishift_pkg::SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [DATA_W-1:0]  a_data,
  input  logic [SHAMT_W-1:0] a_sel,
  input  logic               a_right,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [DATA_W-1:0]  b_data,
  input  logic [SHAMT_W-1:0] b_sel,
  input  logic               b_right,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic [CNT_W-1:0]   a_grants,
  output logic [CNT_W-1:0]   b_grants
);
  import bishift_pkg::*;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]   a_grants_q, a_grants_d;
  logic [CNT_W-1:0]   b_grants_q, b_grants_d;

  logic               grant_a, grant_b;
  logic               can_accept, accept;
  logic [DATA_W-1:0]  sh_data, sh_out;
  logic [SHAMT_W-1:0] sh_sel;
  logic               sh_right;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      if (last_grant_q == ID_A) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  // A held result being drained this cycle frees the register for a new one.
  assign can_accept = (state_q == EMPTY) || (rsp_ready && (state_q == FULL));
  assign a_ready    = can_accept && grant_a;
  assign b_ready    = can_accept && grant_b;
  assign accept     = a_ready || b_ready;

  always_comb begin
    sh_data  = '0;
    sh_sel   = '0;
    sh_right = 1'b0;
    if (grant_a) begin
      sh_data  = a_data;
      sh_sel   = a_sel;
      sh_right = a_right;
    end else if (grant_b) begin
      sh_data  = b_data;
      sh_sel   = b_sel;
      sh_right = b_right;
    end
  end

  bishift_parallel_8 u_shift (
    .data  (sh_data),
    .sel   (sh_sel),
    .right (sh_right),
    .out   (sh_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    a_grants_d   = a_grants_q;
    b_grants_d   = b_grants_q;
    if (accept) begin
      state_d      = FULL;
      rsp_data_d   = sh_out;
      rsp_id_d     = grant_b ? ID_B : ID_A;
      last_grant_d = grant_b ? ID_B : ID_A;
      if (grant_a) begin
        a_grants_d = a_grants_q + CNT_W'(1);
      end else begin
        b_grants_d = b_grants_q + CNT_W'(1);
      end
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= ID_B;
      rsp_data_q   <= '0;
      rsp_id_q     <= ID_A;
      a_grants_q   <= '0;
      b_grants_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      a_grants_q   <= a_grants_d;
      b_grants_q   <= b_grants_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign a_grants  = a_grants_q;
  assign b_grants  = b_grants_q;

endmodule

// File: tb/tb_bishift_arb_ctrl_8.sv
// Directed and randomized bench for bishift_arb_ctrl_8 against a transaction-level
// reference model; a second instance with 2-bit counters exercises wrap-around.
module tb_bishift_arb_ctrl_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_right, b_valid, b_right, rsp_ready;
  logic [7:0]  a_data, b_data;
  logic [2:0]  a_sel, b_sel;

  logic        a_ready, b_ready, rsp_valid, rsp_id;
  logic [7:0]  rsp_data;
  logic [15:0] a_grants, b_grants;

  logic        w_a_ready, w_b_ready, w_rsp_valid, w_rsp_id;
  logic [7:0]  w_rsp_data;
  logic [1:0]  w_a_grants, w_b_grants;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_full;
  logic [7:0] m_data;
  bit         m_id;
  bit         m_last;
  int         m_ag, m_bg;
  int         winner;
  bit         exp_ar, exp_br;

  always #5 clk = ~clk;

  bishift_arb_ctrl_8 #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_sel(a_sel), .a_right(a_right),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_sel(b_sel), .b_right(b_right),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .a_grants(a_grants), .b_grants(b_grants)
  );

  bishift_arb_ctrl_8 #(.CNT_W(2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(w_a_ready), .a_data(a_data), .a_sel(a_sel), .a_right(a_right),
    .b_valid(b_valid), .b_ready(w_b_ready), .b_data(b_data), .b_sel(b_sel), .b_right(b_right),
    .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data), .rsp_id(w_rsp_id),
    .a_grants(w_a_grants), .b_grants(w_b_grants)
  );

  function automatic logic [7:0] shift_ref(input logic [7:0] d, input logic [2:0] s, input bit r);
    int v;
    int p;
    v = int'(d);
    p = 1 << int'(s);
    return r ? 8'(v / p) : 8'((v * p) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_data = 8'h00;
    m_id   = 1'b0;
    m_last = 1'b1;
    m_ag   = 0;
    m_bg   = 0;
  endtask

  task automatic check_outputs();
    chk("rsp_valid", rsp_valid, m_full);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", rsp_id, m_id);
    chk("a_grants", a_grants, m_ag % 65536);
    chk("b_grants", b_grants, m_bg % 65536);
    chk("wrap_rsp_valid", w_rsp_valid, m_full);
    chk("wrap_a_grants", w_a_grants, m_ag % 4);
    chk("wrap_b_grants", w_b_grants, m_bg % 4);
  endtask

  task automatic drive(input bit av, input logic [7:0] ad, input logic [2:0] as, input bit ar,
                       input bit bv, input logic [7:0] bd, input logic [2:0] bs, input bit br,
                       input bit rr);
    a_valid = av; a_data = ad; a_sel = as; a_right = ar;
    b_valid = bv; b_data = bd; b_sel = bs; b_right = br;
    rsp_ready = rr;
  endtask

  // Called mid-cycle; checks readies, clocks one edge, then checks registered outputs.
  task automatic cycle();
    bit can;
    #1;
    can = !m_full || rsp_ready;
    if (a_valid && b_valid) winner = (m_last == 1'b1) ? 0 : 1;
    else if (a_valid)       winner = 0;
    else if (b_valid)       winner = 1;
    else                    winner = -1;
    exp_ar = can && (winner == 0);
    exp_br = can && (winner == 1);
    chk("a_ready", a_ready, exp_ar);
    chk("b_ready", b_ready, exp_br);
    @(posedge clk);
    if (can && winner >= 0) begin
      m_full = 1'b1;
      m_id   = winner[0];
      m_last = winner[0];
      if (winner == 0) begin
        m_data = shift_ref(a_data, a_sel, a_right);
        m_ag++;
      end else begin
        m_data = shift_ref(b_data, b_sel, b_right);
        m_bg++;
      end
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int wrap_exp[5];
    bit pend_a, pend_b;
    logic [7:0] held;
    wrap_exp = '{1, 2, 3, 0, 1};
    rst_n = 1'b1;
    drive(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
    #1;
    do_reset();

    // Single A command
    drive(1, 8'b10100101, 3'd1, 1, 0, 8'h00, 3'd0, 0, 1);
    cycle();
    chk("single_ready", exp_ar, 1'b1);
    chk("single_data", rsp_data, 8'b01010010);
    chk("single_id", rsp_id, 1'b0);
    drive(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
    cycle();

    // Both valid every cycle: strict alternation starting with A
    do_reset();
    drive(1, 8'b10100101, 3'd4, 1, 1, 8'b10100101, 3'd5, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_valid", rsp_valid, 1'b1);
      chk("alt_id", rsp_id, k[0]);
      chk("alt_data", rsp_data, k[0] ? 8'b10100000 : 8'b00001010);
    end
    chk("alt_a_grants", a_grants, 16'd2);
    chk("alt_b_grants", b_grants, 16'd2);

    // Backpressure
    do_reset();
    drive(1, 8'b10100101, 3'd1, 1, 0, 8'h00, 3'd0, 0, 0);
    cycle();
    held = rsp_data;
    drive(0, 8'h00, 3'd0, 0, 1, 8'b10100101, 3'd3, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_b_ready", exp_br, 1'b0);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, held);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", b_ready, 1'b1);
    cycle();
    chk("bp_data", rsp_data, 8'b00101000);
    chk("bp_id", rsp_id, 1'b1);

    // Boundary shift amounts
    do_reset();
    drive(1, 8'b10100101, 3'd0, 1, 0, 8'h00, 3'd0, 0, 1);
    cycle();
    chk("sel0_right", rsp_data, 8'b10100101);
    drive(0, 8'h00, 3'd0, 0, 1, 8'b10100101, 3'd0, 0, 1);
    cycle();
    chk("sel0_left", rsp_data, 8'b10100101);
    drive(1, 8'hFF, 3'd7, 1, 0, 8'h00, 3'd0, 0, 1);
    cycle();
    chk("sel7_right", rsp_data, 8'h01);
    drive(1, 8'hFF, 3'd7, 0, 0, 8'h00, 3'd0, 0, 1);
    cycle();
    chk("sel7_left", rsp_data, 8'h80);

    // Asynchronous reset while holding a result
    drive(0, 8'h00, 3'd0, 0, 1, 8'h3C, 3'd2, 1, 0);
    cycle();
    drive(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 0);
    chk("pre_reset_full", rsp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_a_grants", a_grants, 16'd0);
    chk("async_rst_b_grants", b_grants, 16'd0);
    model_reset();
    rst_n = 1'b1;
    drive(1, 8'h0F, 3'd2, 0, 1, 8'hF0, 3'd2, 1, 1);
    cycle();
    chk("post_rst_a_first", rsp_id, 1'b0);

    // Counter wrap on the 2-bit instance
    do_reset();
    drive(1, 8'h5A, 3'd2, 1, 0, 8'h00, 3'd0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("wrap_seq", w_a_grants, wrap_exp[k]);
    end

    // Randomized traffic; inputs held while a request is pending
    do_reset();
    drive(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1);
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = 8'($urandom);
        a_sel   = 3'($urandom);
        a_right = 1'($urandom);
      end
      if (!pend_b) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = 8'($urandom);
        b_sel   = 3'($urandom);
        b_right = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      pend_a = a_valid && !exp_ar;
      pend_b = b_valid && !exp_br;
      if (n == 200) begin
        do_reset();
        pend_a = 1'b0;
        pend_b = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
